// File: rtl/dco_lock_ctrl.sv
// DCO tuning controller: steps coarse/fine ring-oscillator codes from
// per-reference-cycle frequency and phase error words, and tracks lock
// progress (UNLOCKED -> COARSE -> FINE -> PHASE) plus a braking mode
// that uses large coarse steps while the frequency error is big.
//
// Ports:
//   refclk, resetn           reference clock / async active-low reset
//   freq_err(_valid)         signed measured-minus-target edge count
//   phase_err(_valid)        signed phase error, positive = DCO leading
//   coarse_code, fine_code   registered DCO codes
//   lock_state, brake_state  registered controller states
//   locked                   high iff lock_state == PHASE_LOCKED

package dco_lock_pkg;
    typedef enum logic [1:0] {
        UNLOCKED,
        COARSE_FREQ_LOCKED,
        FINE_FREQ_LOCKED,
        PHASE_LOCKED
    } lock_state_t;

    typedef enum logic [1:0] {
        BRAKES_OFF,
        BRAKING,
        RECOVERING
    } brake_state_t;
endpackage

module dco_lock_ctrl
    import dco_lock_pkg::*;
#(
    parameter int COARSE_W   = 6,
    parameter int FINE_W     = 8,
    parameter int ERR_W      = 10,
    parameter int LOCK_CNT   = 16,
    parameter int COARSE_TOL = 2,
    parameter int FINE_TOL   = 0,
    parameter int PHASE_TOL  = 2,
    parameter int BRAKE_THR  = 32,
    parameter int BRAKE_HOLD = 8,
    parameter int F_PER_C    = 5
) (
    input  logic                refclk,
    input  logic                resetn,
    input  logic [ERR_W-1:0]    freq_err,
    input  logic                freq_err_valid,
    input  logic [ERR_W-1:0]    phase_err,
    input  logic                phase_err_valid,
    output logic [COARSE_W-1:0] coarse_code,
    output logic [FINE_W-1:0]   fine_code,
    output lock_state_t         lock_state,
    output brake_state_t        brake_state,
    output logic                locked
);

    localparam int AW  = ERR_W + 1;
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam int HCW = $clog2(BRAKE_HOLD + 1);

    localparam logic [COARSE_W-1:0] COARSE_MID =
        {1'b1, {(COARSE_W-1){1'b0}}};
    localparam logic [COARSE_W-1:0] COARSE_MAX = '1;
    localparam logic [FINE_W-1:0] FINE_MID =
        {1'b1, {(FINE_W-1){1'b0}}};
    localparam logic [FINE_W-1:0] FINE_MAX = '1;
    localparam logic [FINE_W-1:0] F_STEP = FINE_W'(F_PER_C);
    localparam logic [FINE_W-1:0] F_ONE = FINE_W'(1);
    localparam logic [COARSE_W-1:0] C_ONE = COARSE_W'(1);

    localparam logic [AW-1:0] C_TOL = AW'(COARSE_TOL);
    localparam logic [AW-1:0] F_TOL = AW'(FINE_TOL);
    localparam logic [AW-1:0] P_TOL = AW'(PHASE_TOL);
    localparam logic [AW-1:0] P_EXIT = AW'(4 * PHASE_TOL);
    localparam logic [AW-1:0] B_THR = AW'(BRAKE_THR);

    localparam logic [LCW-1:0] LCNT_LAST = LCW'(LOCK_CNT - 1);
    localparam logic [LCW-1:0] LCNT_MAX = LCW'(LOCK_CNT);
    localparam logic [LCW-1:0] LCNT_ONE = LCW'(1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(BRAKE_HOLD - 1);
    localparam logic [HCW-1:0] HCNT_ONE = HCW'(1);

    // One extra bit so that the most negative error has a magnitude.
    function automatic logic [AW-1:0] abs_err(
        input logic [ERR_W-1:0] e
    );
        logic [AW-1:0] x;
        x = {e[ERR_W-1], e};
        return e[ERR_W-1] ? -x : x;
    endfunction

    function automatic logic [COARSE_W-1:0] coarse_move(
        input logic [COARSE_W-1:0] c,
        input logic                up,
        input logic                big
    );
        logic [COARSE_W:0] step;
        logic [COARSE_W:0] sum;
        step = big ? (COARSE_W+1)'(4) : (COARSE_W+1)'(1);
        sum  = {1'b0, c} + step;
        if (up) begin
            return (sum > {1'b0, COARSE_MAX}) ? COARSE_MAX
                                              : sum[COARSE_W-1:0];
        end
        return ({1'b0, c} < step) ? '0 : c - step[COARSE_W-1:0];
    endfunction

    // Fine step of one; at a fine rail, borrow/carry into coarse and
    // move fine back toward mid by the coarse/fine step ratio.
    function automatic logic [COARSE_W+FINE_W-1:0] fine_move(
        input logic [COARSE_W-1:0] c,
        input logic [FINE_W-1:0]   f,
        input logic                up
    );
        logic [COARSE_W-1:0] cn;
        logic [FINE_W-1:0]   fn;
        cn = c;
        fn = f;
        if (up) begin
            if (f != FINE_MAX) begin
                fn = f + F_ONE;
            end else if (c != COARSE_MAX) begin
                cn = c + C_ONE;
                fn = f - F_STEP;
            end
        end else begin
            if (f != '0) begin
                fn = f - F_ONE;
            end else if (c != '0) begin
                cn = c - C_ONE;
                fn = f + F_STEP;
            end
        end
        return {cn, fn};
    endfunction

    lock_state_t         state_q, state_d;
    brake_state_t        brake_q, brake_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [FINE_W-1:0]   fine_q, fine_d;
    logic [LCW-1:0]      lcnt_q, lcnt_d;
    logic [HCW-1:0]      hcnt_q, hcnt_d;
    // Sign of previous freq sample: bit1 negative, bit0 positive.
    logic [1:0]          psgn_q, psgn_d;

    logic [AW-1:0] f_abs;
    logic [AW-1:0] p_abs;
    logic          f_neg;
    logic          f_pos;
    logic          p_neg;
    logic          f_flip;
    logic          exited;

    assign f_abs  = abs_err(freq_err);
    assign p_abs  = abs_err(phase_err);
    assign f_neg  = freq_err[ERR_W-1];
    assign f_pos  = !f_neg && (freq_err != '0);
    assign p_neg  = phase_err[ERR_W-1];
    assign f_flip = (f_neg && psgn_q[0]) || (f_pos && psgn_q[1]);

    always_comb begin
        state_d  = state_q;
        brake_d  = brake_q;
        coarse_d = coarse_q;
        fine_d   = fine_q;
        lcnt_d   = lcnt_q;
        hcnt_d   = hcnt_q;
        psgn_d   = psgn_q;
        exited   = 1'b0;

        if (freq_err_valid) begin
            psgn_d = {f_neg, f_pos};
            unique case (state_q)
                UNLOCKED: begin
                    unique case (brake_q)
                        BRAKES_OFF: begin
                            if (f_abs > B_THR) begin
                                brake_d = BRAKING;
                            end
                        end
                        BRAKING: begin
                            if (f_abs <= B_THR || f_flip) begin
                                brake_d = RECOVERING;
                                hcnt_d  = '0;
                            end
                        end
                        RECOVERING: begin
                            if (f_abs > B_THR) begin
                                brake_d = BRAKING;
                                hcnt_d  = '0;
                            end else if (hcnt_q == HOLD_LAST) begin
                                brake_d = BRAKES_OFF;
                                hcnt_d  = '0;
                            end else begin
                                hcnt_d = hcnt_q + HCNT_ONE;
                            end
                        end
                        default: begin
                            brake_d = BRAKES_OFF;
                            hcnt_d  = '0;
                        end
                    endcase

                    // Step size follows the brake mode this sample
                    // lands in, so the engaging sample already steps 4.
                    if (f_abs > C_TOL) begin
                        coarse_d = coarse_move(coarse_q, f_neg,
                                               brake_d == BRAKING);
                        lcnt_d = '0;
                    end else if (brake_q != BRAKES_OFF) begin
                        lcnt_d = '0;
                    end else if (lcnt_q == LCNT_LAST) begin
                        state_d = COARSE_FREQ_LOCKED;
                        lcnt_d  = '0;
                    end else begin
                        lcnt_d = lcnt_q + LCNT_ONE;
                    end
                end
                default: begin
                    if (f_abs > C_TOL) begin
                        state_d = UNLOCKED;
                        lcnt_d  = '0;
                    end else if (state_q == COARSE_FREQ_LOCKED) begin
                        if (f_abs > F_TOL) begin
                            {coarse_d, fine_d} =
                                fine_move(coarse_q, fine_q, f_neg);
                            lcnt_d = '0;
                        end else if (lcnt_q == LCNT_LAST) begin
                            state_d = FINE_FREQ_LOCKED;
                            lcnt_d  = '0;
                        end else begin
                            lcnt_d = lcnt_q + LCNT_ONE;
                        end
                    end
                end
            endcase
            exited = (state_d != state_q);
        end

        // Phase sample applies after the freq step, unless the freq
        // sample moved the lock state this cycle.
        if (phase_err_valid && !exited) begin
            unique case (state_q)
                FINE_FREQ_LOCKED: begin
                    if (p_abs > P_TOL) begin
                        {coarse_d, fine_d} =
                            fine_move(coarse_d, fine_d, p_neg);
                        lcnt_d = '0;
                    end else if (lcnt_q == LCNT_LAST) begin
                        state_d = PHASE_LOCKED;
                        lcnt_d  = '0;
                    end else begin
                        lcnt_d = lcnt_q + LCNT_ONE;
                    end
                end
                PHASE_LOCKED: begin
                    if (p_abs > P_TOL) begin
                        {coarse_d, fine_d} =
                            fine_move(coarse_d, fine_d, p_neg);
                        lcnt_d = '0;
                        if (p_abs > P_EXIT) begin
                            state_d = FINE_FREQ_LOCKED;
                        end
                    end else if (lcnt_q != LCNT_MAX) begin
                        lcnt_d = lcnt_q + LCNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end

        if (state_d != UNLOCKED) begin
            brake_d = BRAKES_OFF;
            hcnt_d  = '0;
        end
    end

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= UNLOCKED;
            brake_q  <= BRAKES_OFF;
            coarse_q <= COARSE_MID;
            fine_q   <= FINE_MID;
            lcnt_q   <= '0;
            hcnt_q   <= '0;
            psgn_q   <= '0;
        end else begin
            state_q  <= state_d;
            brake_q  <= brake_d;
            coarse_q <= coarse_d;
            fine_q   <= fine_d;
            lcnt_q   <= lcnt_d;
            hcnt_q   <= hcnt_d;
            psgn_q   <= psgn_d;
        end
    end

    assign coarse_code = coarse_q;
    assign fine_code   = fine_q;
    assign lock_state  = state_q;
    assign brake_state = brake_q;
    assign locked      = (state_q == PHASE_LOCKED);

endmodule
